// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus used by the memory-access stage.
// The pipeline side (master) issues requests; the memory side (slave)
// answers with read data and a completion strobe.
interface mem_stage_if #(
  parameter int DATA_W = 16
);

  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit five-stage pipeline.
// Sits between the X/M and M/W flops, drives a variable-latency data-memory
// handshake, forwards writeback data into store data, stalls the front of
// the pipeline while an access is outstanding and feeds bubbles into M/W.
// A wait that never completes parks the stage in a sticky error state.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,

  // X/M pipeline fields
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemtoReg_in,
  input  logic              SavePC_in,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] oldPC_in,
  input  logic [DATA_W-1:0] newPC_in,
  input  logic [3:0]        reg_dest_in,
  input  logic [3:0]        Source2_in,

  // Writeback stage, for MEM-to-MEM forwarding
  input  logic              wb_RegWrite,
  input  logic [3:0]        wb_reg_dest,
  input  logic [DATA_W-1:0] wb_data,

  // Data-memory handshake
  mem_stage_if.master       mem,

  // Pipeline control
  output logic              stall,

  // M/W pipeline fields
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              SavePC_out,
  output logic              halt_out,
  output logic [DATA_W-1:0] ALUresult_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] oldPC_out,
  output logic [DATA_W-1:0] newPC_out,
  output logic [3:0]        reg_dest_out,

  // Status
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Wait counter only needs to reach TIMEOUT-1 before the stage gives up.
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_wr;
  logic [WCNT_W-1:0] wait_cnt;
  logic              err_q;
  logic [CNT_W-1:0]  stall_cnt;

  logic              access;
  logic              fwd;
  logic [DATA_W-1:0] store_data;

  logic              req_c;
  logic              wr_c;
  logic [DATA_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              stall_c;
  logic              done_rd_c;
  logic              capture_c;
  logic              enter_err_c;

  // A write wins when both read and write are flagged, so mem_wr simply
  // follows MemWrite_in; the store picks up a result still in writeback
  // unless it targets r0, which never holds a forwarded value.
  assign access     = MemRead_in | MemWrite_in;
  assign fwd        = MemWrite_in & wb_RegWrite &
                      (wb_reg_dest == Source2_in) & (wb_reg_dest != 4'd0);
  assign store_data = fwd ? wb_data : b_in;

  // Next-state and handshake decisions for the access FSM.
  always_comb begin
    state_next  = state;
    req_c       = 1'b0;
    wr_c        = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    stall_c     = 1'b0;
    done_rd_c   = 1'b0;
    capture_c   = 1'b0;
    enter_err_c = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          req_c   = 1'b1;
          wr_c    = MemWrite_in;
          addr_c  = ALUresult_in;
          wdata_c = store_data;
          if (mem.mem_ready) begin
            done_rd_c = ~MemWrite_in;
          end else begin
            stall_c    = 1'b1;
            capture_c  = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        req_c   = 1'b1;
        wr_c    = cap_wr;
        addr_c  = cap_addr;
        wdata_c = cap_wdata;
        if (mem.mem_ready) begin
          done_rd_c  = ~cap_wr;
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
          if (wait_cnt == WCNT_LAST) begin
            enter_err_c = 1'b1;
            state_next  = ERR;
          end
        end
      end
      ERR: begin
        stall_c = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Drive the bus and the M/W fields; everything combinational reads 0 in reset,
  // and a stalled cycle becomes a bubble by clearing the side-effecting controls.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    stall         = 1'b0;
    RegWrite_out  = 1'b0;
    MemtoReg_out  = 1'b0;
    SavePC_out    = 1'b0;
    halt_out      = 1'b0;
    ALUresult_out = '0;
    mem_data_out  = '0;
    oldPC_out     = '0;
    newPC_out     = '0;
    reg_dest_out  = '0;
    if (rst) begin
      mem.mem_req   = req_c;
      mem.mem_wr    = wr_c;
      mem.mem_addr  = addr_c;
      mem.mem_wdata = wdata_c;
      stall         = stall_c;
      RegWrite_out  = RegWrite_in & ~stall_c;
      MemtoReg_out  = MemtoReg_in & ~stall_c;
      SavePC_out    = SavePC_in & ~stall_c;
      halt_out      = halt_in & ~stall_c;
      ALUresult_out = ALUresult_in;
      mem_data_out  = done_rd_c ? mem.mem_rdata : '0;
      oldPC_out     = oldPC_in;
      newPC_out     = newPC_in;
      reg_dest_out  = reg_dest_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the request on entry to WAIT so the bus stays stable even though
  // the writeback forwarding source keeps moving underneath it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
    end else if (capture_c) begin
      cap_addr  <= ALUresult_in;
      cap_wdata <= store_data;
      cap_wr    <= MemWrite_in;
    end
  end

  // Count cycles spent in WAIT; restarted for every new outstanding access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (capture_c) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (enter_err_c) begin
      err_q <= 1'b1;
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign mem_err      = err_q;
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard on completed memory accesses.
// Built with TIMEOUT=4 and a 3-bit stall counter so timeout and saturation
// are reachable in a few cycles.
module tb_mem_stage;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    logic        regw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, SavePC_in, halt_in;
  logic [DATA_W-1:0] ALUresult_in, b_in, oldPC_in, newPC_in, wb_data;
  logic [3:0]        reg_dest_in, Source2_in, wb_reg_dest;
  logic              wb_RegWrite;

  logic              stall, RegWrite_out, MemtoReg_out, SavePC_out, halt_out, mem_err;
  logic [DATA_W-1:0] ALUresult_out, mem_data_out, oldPC_out, newPC_out;
  logic [3:0]        reg_dest_out;
  logic [CNT_W-1:0]  stall_cycles;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  mem_stage_if #(.DATA_W(DATA_W)) mem_if ();

  mem_stage #(.DATA_W(DATA_W), .TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .SavePC_in(SavePC_in), .halt_in(halt_in),
    .ALUresult_in(ALUresult_in), .b_in(b_in), .oldPC_in(oldPC_in), .newPC_in(newPC_in),
    .reg_dest_in(reg_dest_in), .Source2_in(Source2_in),
    .wb_RegWrite(wb_RegWrite), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
    .mem(mem_if.master),
    .stall(stall),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .SavePC_out(SavePC_out),
    .halt_out(halt_out), .ALUresult_out(ALUresult_out), .mem_data_out(mem_data_out),
    .oldPC_out(oldPC_out), .newPC_out(newPC_out), .reg_dest_out(reg_dest_out),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0;
    SavePC_in = 0; halt_in = 0;
    ALUresult_in = '0; b_in = '0; oldPC_in = '0; newPC_in = '0;
    reg_dest_in = '0; Source2_in = '0;
    wb_RegWrite = 0; wb_reg_dest = '0; wb_data = '0;
    mem_if.mem_ready = 0; mem_if.mem_rdata = '0;
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic regw, input logic halt,
                                input logic [15:0] addr, input logic [15:0] b,
                                input logic [3:0] src2, input logic [3:0] dest);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = regw; MemtoReg_in = rd;
    halt_in = halt; SavePC_in = 0;
    ALUresult_in = addr; b_in = b; Source2_in = src2; reg_dest_in = dest;
    oldPC_in = 16'h0100; newPC_in = 16'h0102;
  endtask

  task automatic set_wb(input logic we, input logic [3:0] dest, input logic [15:0] data);
    wb_RegWrite = we; wb_reg_dest = dest; wb_data = data;
  endtask

  task automatic set_mem(input logic ready, input logic [15:0] rdata);
    mem_if.mem_ready = ready; mem_if.mem_rdata = rdata;
  endtask

  task automatic expect_access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                               input logic [15:0] mdata, input logic regw);
    exp_t e;
    e.addr = addr; e.wr = wr; e.wdata = wdata; e.mdata = mdata; e.regw = regw;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every completed handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && mem_if.mem_req && mem_if.mem_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_access: got addr %0h, expected no access", mem_if.mem_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("acc_addr", mem_if.mem_addr, e.addr);
        check_output("acc_wr", mem_if.mem_wr, e.wr);
        check_output("acc_wdata", mem_if.mem_wdata, e.wdata);
        check_output("acc_mem_data_out", mem_data_out, e.mdata);
        check_output("acc_RegWrite_out", RegWrite_out, e.regw);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    // Reset state, with live inputs that must be masked
    apply_stimulus(1, 0, 1, 1, 16'h0040, 16'h0, 4'd0, 4'd3);
    set_mem(1, 16'hBEEF);
    #2;
    check_output("rst_mem_req", mem_if.mem_req, 0);
    check_output("rst_stall", stall, 0);
    check_output("rst_mem_err", mem_err, 0);
    check_output("rst_stall_cycles", stall_cycles, 0);
    check_output("rst_halt_out", halt_out, 0);
    check_output("rst_ALUresult_out", ALUresult_out, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    clear_inputs();
    rst = 1;

    // Zero-wait load
    next_cycle();
    apply_stimulus(1, 0, 1, 0, 16'h0040, 16'h0, 4'd0, 4'd3);
    set_mem(1, 16'hBEEF);
    expect_access(16'h0040, 0, 16'h0000, 16'hBEEF, 1);
    @(negedge clk);
    check_output("zw_stall", stall, 0);
    check_output("zw_MemtoReg_out", MemtoReg_out, 1);
    check_output("zw_reg_dest_out", reg_dest_out, 3);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_output("zw_req_drop", mem_if.mem_req, 0);
    check_output("zw_stall_cycles", stall_cycles, 0);

    // Load with three stalled cycles, completing on the fourth
    next_cycle();
    apply_stimulus(1, 0, 1, 0, 16'h0040, 16'h0, 4'd0, 4'd3);
    set_mem(0, 16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("lat_stall", stall, 1);
      check_output("lat_mem_req", mem_if.mem_req, 1);
      check_output("lat_mem_addr", mem_if.mem_addr, 16'h0040);
      check_output("lat_RegWrite_out", RegWrite_out, 0);
      check_output("lat_mem_data_out", mem_data_out, 0);
      next_cycle();
    end
    set_mem(1, 16'h1234);
    expect_access(16'h0040, 0, 16'h0000, 16'h1234, 1);
    @(negedge clk);
    check_output("lat_done_stall", stall, 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_output("lat_stall_cycles", stall_cycles, 3);

    // Store with forwarding from writeback
    next_cycle();
    apply_stimulus(0, 1, 0, 0, 16'h0080, 16'h1111, 4'd5, 4'd0);
    set_wb(1, 4'd5, 16'h2222);
    set_mem(1, 16'hDEAD);
    expect_access(16'h0080, 1, 16'h2222, 16'h0000, 0);
    @(negedge clk);
    check_output("fwd_stall", stall, 0);

    // Forwarding excluded for r0
    next_cycle();
    apply_stimulus(0, 1, 0, 0, 16'h0082, 16'h1111, 4'd0, 4'd0);
    set_wb(1, 4'd0, 16'h2222);
    set_mem(1, 16'hDEAD);
    expect_access(16'h0082, 1, 16'h1111, 16'h0000, 0);
    @(negedge clk);

    // Forwarding excluded when writeback does not write
    next_cycle();
    apply_stimulus(0, 1, 0, 0, 16'h0084, 16'h1111, 4'd5, 4'd0);
    set_wb(0, 4'd5, 16'h2222);
    set_mem(1, 16'hDEAD);
    expect_access(16'h0084, 1, 16'h1111, 16'h0000, 0);
    @(negedge clk);

    // Delayed store keeps the forwarded data captured at launch
    next_cycle();
    apply_stimulus(0, 1, 0, 0, 16'h0090, 16'h1111, 4'd5, 4'd0);
    set_wb(1, 4'd5, 16'h2222);
    set_mem(0, 16'h0000);
    @(negedge clk);
    check_output("dst_stall", stall, 1);
    check_output("dst_wdata_launch", mem_if.mem_wdata, 16'h2222);
    next_cycle();
    set_wb(1, 4'd0, 16'h3333);
    set_mem(1, 16'hDEAD);
    expect_access(16'h0090, 1, 16'h2222, 16'h0000, 0);
    @(negedge clk);
    check_output("dst_done_stall", stall, 0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_output("dst_stall_cycles", stall_cycles, 4);

    // Read and write both set behaves as a write
    next_cycle();
    apply_stimulus(1, 1, 0, 0, 16'h00A0, 16'h4444, 4'd2, 4'd7);
    set_mem(1, 16'hBEEF);
    expect_access(16'h00A0, 1, 16'h4444, 16'h0000, 0);
    @(negedge clk);

    // Non-memory halt passes through; stray mem_ready is ignored
    next_cycle();
    clear_inputs();
    apply_stimulus(0, 0, 1, 1, 16'h0055, 16'h0, 4'd0, 4'd9);
    set_mem(1, 16'hBEEF);
    @(negedge clk);
    check_output("nm_halt_out", halt_out, 1);
    check_output("nm_mem_req", mem_if.mem_req, 0);
    check_output("nm_stall", stall, 0);
    check_output("nm_ALUresult_out", ALUresult_out, 16'h0055);
    check_output("nm_mem_data_out", mem_data_out, 0);
    check_output("nm_oldPC_out", oldPC_out, 16'h0100);
    next_cycle();
    clear_inputs();

    // Reset asserted during the second wait cycle
    next_cycle();
    apply_stimulus(1, 0, 1, 0, 16'h00C0, 16'h0, 4'd0, 4'd4);
    set_mem(0, 16'h0000);
    @(negedge clk);
    check_output("rmw_idle_stall", stall, 1);
    next_cycle();
    @(negedge clk);
    check_output("rmw_wait1_req", mem_if.mem_req, 1);
    next_cycle();
    #2;
    rst = 0;
    #1;
    check_output("rmw_mem_req", mem_if.mem_req, 0);
    check_output("rmw_stall", stall, 0);
    check_output("rmw_stall_cycles", stall_cycles, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1;
    next_cycle();
    apply_stimulus(0, 0, 0, 1, 16'h0077, 16'h0, 4'd0, 4'd0);
    @(negedge clk);
    check_output("rmw_halt_out", halt_out, 1);
    check_output("rmw_post_req", mem_if.mem_req, 0);
    check_output("rmw_post_stall", stall, 0);
    next_cycle();
    clear_inputs();

    // Timeout after four wait cycles, then sticky error with saturating count
    next_cycle();
    apply_stimulus(1, 0, 1, 0, 16'h00E0, 16'h0, 4'd0, 4'd6);
    set_mem(0, 16'h0000);
    @(negedge clk);
    check_output("to_idle_stall", stall, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check_output("to_wait_req", mem_if.mem_req, 1);
      check_output("to_wait_stall", stall, 1);
      check_output("to_wait_err", mem_err, 0);
    end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 3) set_mem(1, 16'hBEEF);
      @(negedge clk);
      check_output("to_err_req", mem_if.mem_req, 0);
      check_output("to_err_stall", stall, 1);
      check_output("to_err_flag", mem_err, 1);
      check_output("to_err_RegWrite_out", RegWrite_out, 0);
      check_output("to_err_stall_cycles", stall_cycles, (4 + k > 7) ? 7 : 4 + k);
    end
    #1;
    rst = 0;
    #1;
    check_output("to_rst_err", mem_err, 0);
    check_output("to_rst_stall_cycles", stall_cycles, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1;
    next_cycle();
    @(negedge clk);
    check_output("to_post_req", mem_if.mem_req, 0);
    check_output("to_post_stall", stall, 0);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit five-stage pipeline, between the X/M pipeline flops and the M/W pipeline flops.
- Consumes the registered X/M control and data fields and drives a variable-latency data-memory request/ready handshake.
- Forwards writeback data into store data (MEM-to-MEM).
- Stalls the upstream pipeline while an access is outstanding and injects bubbles into M/W.
- Counts stall cycles and flags memory timeouts.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 64, maximum wait cycles for mem_ready before error abort.
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, SavePC_in, halt_in  in  1 each  control fields from X/M flops.
- ALUresult_in  in  DATA_W  effective address, or ALU result for non-memory instructions.
- b_in  in  DATA_W  store data before forwarding.
- oldPC_in, newPC_in  in  DATA_W  pass-through PC values.
- reg_dest_in, Source2_in  in  4 each  destination register; store-data source register.
- wb_RegWrite  in  1  writeback-stage write enable.
- wb_reg_dest  in  4  writeback-stage destination register.
- wb_data  in  DATA_W  writeback-stage result.
- mem_req  out  1  data-memory request.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DATA_W  request address.
- mem_wdata  out  DATA_W  request write data.
- mem_rdata  in  DATA_W  read data; valid when mem_ready is high.
- mem_ready  in  1  access complete this cycle.
- stall  out  1  1 = freeze PC and the F/D, D/X and X/M flops (drives their wen low).
- RegWrite_out, MemtoReg_out, SavePC_out, halt_out  out  1 each  to M/W flops.
- ALUresult_out, mem_data_out, oldPC_out, newPC_out  out  DATA_W  to M/W flops.
- reg_dest_out  out  4  to M/W flops.
- mem_err  out  1  sticky timeout error.
- stall_cycles  out  CNT_W  saturating count of cycles with stall high.

Behaviour:
- Reset values: state IDLE; captured address/data/wr registers 0; stall 0; mem_req 0; mem_err 0; stall_cycles 0.
- While reset is asserted, all combinational outputs are forced to 0.
- access = MemRead_in | MemWrite_in.
  - If both are 1, treat the instruction as a write.
- Forwarding:
  - fwd = MemWrite_in & wb_RegWrite & (wb_reg_dest == Source2_in) & (wb_reg_dest != 0).
  - Store data = fwd ? wb_data : b_in.
- State IDLE:
  - If access: mem_req=1 combinationally, mem_addr=ALUresult_in, mem_wr=MemWrite_in, mem_wdata=store data.
  - If access and mem_ready=1 in the same cycle: zero-wait completion, stall=0, stay IDLE.
  - If access and mem_ready=0: stall=1; capture addr/wdata/wr; clear the wait counter; next state WAIT.
  - No access: mem_req=0, stall=0.
- State WAIT:
  - mem_req=1; mem_addr/mem_wdata/mem_wr come from the captured registers and are stable until ready.
  - Wait counter increments each cycle.
  - mem_ready=1: stall=0 this cycle, next state IDLE.
  - Counter reaches TIMEOUT-1 without ready: next state ERR, mem_err set. mem_req drops the following cycle.
- State ERR:
  - mem_req=0, stall=1, mem_err=1 permanently; only reset exits.
- M/W outputs:
  - When stall=0: control and data fields pass through combinationally.
  - mem_data_out = mem_rdata when the completing access is a read, else 0.
  - When stall=1: RegWrite_out=0, halt_out=0, SavePC_out=0, MemtoReg_out=0, and the other outputs are unchanged. M/W keeps capturing and receives a bubble.
- halt_in on a non-memory instruction passes through at 0 latency.
- stall_cycles increments every cycle stall=1 and saturates at all-ones.
- mem_ready in IDLE with no access is ignored.
- X/M inputs are held stable by stall, so no re-launch occurs on the completing cycle.
- Reset asserted mid-WAIT aborts immediately: mem_req=0, state IDLE. No partial write is reported.

Test Plan:
- Load, zero wait: MemRead=1, ALUresult=0x0040, memory returns 0xBEEF with mem_ready in the same cycle -> mem_req high 1 cycle, stall never high, mem_data_out=0xBEEF, RegWrite_out=1.
- Load, 3-cycle latency: mem_ready on the 4th cycle -> stall high exactly 3 cycles; mem_addr=0x0040 stable throughout; RegWrite_out=0 for 3 cycles, then 1 with data; stall_cycles=3.
- Store with forwarding: MemWrite=1, Source2=5, b_in=0x1111, wb_RegWrite=1, wb_reg_dest=5, wb_data=0x2222 -> mem_wdata=0x2222, mem_wr=1.
- Forwarding excluded: same as above but Source2=0 and wb_reg_dest=0 -> mem_wdata=0x1111.
- Timeout: TIMEOUT=4, mem_ready held low -> stall high, mem_err=1 after 4 WAIT cycles, mem_req then 0, stall stays 1 until reset.
- Reset mid-WAIT: assert rst low during the 2nd wait cycle -> mem_req, stall and stall_cycles go to 0 asynchronously. After release, a halt_in=1 non-memory instruction gives halt_out=1 the same cycle.
